// File: rtl/uart_pkg.sv
// Shared UART types and defaults: arbiter state encoding and parameter defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } uart_arb_state_t;

  localparam int UART_ARB_NREQ      = 4;
  localparam int UART_ARB_TO_CYCLES = 4096;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module uart_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [$clog2(NREQ)-1:0] pick_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] idx_s;

  // Walk offsets from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    idx_s  = '0;
    for (int s = NREQ; s >= 1; s--) begin
      idx_s = IW'((int'(ptr_i) + s) % NREQ);
      if (req_i[idx_s]) begin
        pick_o = idx_s;
        any_o  = 1'b1;
      end else begin
        any_o  = any_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NREQ byte requesters, with a frame watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ      = UART_ARB_NREQ,
  parameter int TO_CYCLES = UART_ARB_TO_CYCLES
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NREQ-1:0]         Req,
  input  logic [8*NREQ-1:0]       ReqData,
  output logic [NREQ-1:0]         Gnt,
  output logic [NREQ-1:0]         Done,
  output logic                    Timeout,
  output logic                    Busy,
  output logic [$clog2(NREQ)-1:0] OwnerId,
  output logic                    TxEn,
  output logic [7:0]              TxData,
  input  logic                    TxDone
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TO_CYCLES);

  uart_arb_state_t state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            txen_q, txen_d;
  logic [7:0]      txdata_q, txdata_d;

  logic [IW-1:0]   pick_s;
  logic            any_s;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (Req),
    .ptr_i  (ptr_q),
    .pick_o (pick_s),
    .any_o  (any_s)
  );

  // Next-state and registered-output decode for the IDLE/SEND/GAP sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    done_d    = '0;
    timeout_d = 1'b0;
    owner_d   = owner_q;
    txen_d    = txen_q;
    txdata_d  = txdata_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          gnt_d    = NREQ'(1) << pick_s;
          txdata_d = ReqData[{pick_s, 3'b000} +: 8];
          owner_d  = pick_s;
          ptr_d    = pick_s;
          txen_d   = 1'b1;
          cnt_d    = '0;
          state_d  = SEND;
        end else begin
          state_d  = IDLE;
        end
      end
      SEND: begin
        // TxDone takes priority over a watchdog expiry on the same edge.
        if (TxDone) begin
          txen_d  = 1'b0;
          done_d  = NREQ'(1) << owner_q;
          state_d = GAP;
        end else if (cnt_q == CW'(TO_CYCLES - 1)) begin
          txen_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        txen_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        txen_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset parks ptr on the last requester so index 0 wins first.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NREQ - 1);
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      txen_q    <= 1'b0;
      txdata_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      txen_q    <= txen_d;
      txdata_q  <= txdata_d;
    end
  end

  assign Gnt     = gnt_q;
  assign Done    = done_q;
  assign Timeout = timeout_q;
  assign Busy    = busy_q;
  assign OwnerId = owner_q;
  assign TxEn    = txen_q;
  assign TxData  = txdata_q;

endmodule
